// File: rtl/register_file_pkg.sv
// Processor-wide constants shared by the register file and its read ports.
package register_file_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 6;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 6'd0;

endpackage

// File: rtl/register_file_read_port.sv
// Combinational read port: selects one register and forces the zero register to read as 0.
module register_file_read_port
    import register_file_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int ADDR_W_P = REG_ADDR_W
) (
    input  logic [DATA_W_P-1:0] regs_i [2**ADDR_W_P],
    input  logic [ADDR_W_P-1:0] addr_i,
    output logic [DATA_W_P-1:0] data_o
);

    always_comb begin
        data_o = regs_i[addr_i];
        // Override keeps address 0 at zero even if storage were ever disturbed.
        if (addr_i == ADDR_W_P'(ZERO_REG)) begin
            data_o = '0;
        end
    end

endmodule

// File: rtl/register_file.sv
// 64 x 32 register file: two combinational read ports, one synchronous write port,
// asynchronous active-high reset clearing all registers.
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_W = register_file_pkg::DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] R1,
    input  logic [ADDR_W-1:0] R2,
    input  logic [ADDR_W-1:0] WR,
    input  logic [DATA_W-1:0] WD,
    input  logic              RegWrite,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];

    always_comb begin
        regs_d = regs_q;
        if (RegWrite && (WR != ADDR_W'(ZERO_REG))) begin
            regs_d[WR] = WD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    register_file_read_port #(
        .DATA_W_P (DATA_W),
        .ADDR_W_P (ADDR_W)
    ) u_rd1 (
        .regs_i (regs_q),
        .addr_i (R1),
        .data_o (RD1)
    );

    register_file_read_port #(
        .DATA_W_P (DATA_W),
        .ADDR_W_P (ADDR_W)
    ) u_rd2 (
        .regs_i (regs_q),
        .addr_i (R2),
        .data_o (RD2)
    );

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: vector table for write/read traffic plus
// hand-written sequences for read-during-write and asynchronous reset.
module tb_register_file;

    logic        clk;
    logic        reset;
    logic [5:0]  R1, R2, WR;
    logic [31:0] WD;
    logic        RegWrite;
    logic [31:0] RD1, RD2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [5:0]  wr;
        logic [31:0] wd;
        logic [5:0]  r1;
        logic [5:0]  r2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t vecs [10];

    register_file dut (
        .clk      (clk),
        .reset    (reset),
        .R1       (R1),
        .R2       (R2),
        .WR       (WR),
        .WD       (WD),
        .RegWrite (RegWrite),
        .RD1      (RD1),
        .RD2      (RD2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 6'd0,  32'h0000_0019, 6'd0,  6'd0,  32'h0,          32'h0};
        vecs[1] = '{1'b1, 6'd1,  32'h0000_0024, 6'd0,  6'd1,  32'h0,          32'h24};
        vecs[2] = '{1'b0, 6'd1,  32'h0,         6'd1,  6'd1,  32'h24,         32'h24};
        vecs[3] = '{1'b0, 6'd1,  32'h0,         6'd1,  6'd1,  32'h24,         32'h24};
        vecs[4] = '{1'b0, 6'd5,  32'hDEAD_BEEF, 6'd5,  6'd1,  32'h0,          32'h24};
        vecs[5] = '{1'b1, 6'd5,  32'hDEAD_BEEF, 6'd5,  6'd1,  32'hDEAD_BEEF,  32'h24};
        vecs[6] = '{1'b1, 6'd63, 32'h1234_5678, 6'd63, 6'd5,  32'h1234_5678,  32'hDEAD_BEEF};
        vecs[7] = '{1'b1, 6'd2,  32'hFFFF_FFFF, 6'd2,  6'd63, 32'hFFFF_FFFF,  32'h1234_5678};
        vecs[8] = '{1'b1, 6'd1,  32'h0,         6'd1,  6'd2,  32'h0,          32'hFFFF_FFFF};
        vecs[9] = '{1'b1, 6'd1,  32'h0000_0024, 6'd1,  6'd0,  32'h24,         32'h0};

        reset    = 1'b1;
        R1       = 6'd0;
        R2       = 6'd1;
        WR       = 6'd0;
        WD       = 32'h0;
        RegWrite = 1'b0;
        #1;
        check("reset_rd1", RD1, 32'h0);
        check("reset_rd2", RD2, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_reset_rd1", RD1, 32'h0);
        check("post_reset_rd2", RD2, 32'h0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            RegWrite = vecs[i].we;
            WR       = vecs[i].wr;
            WD       = vecs[i].wd;
            R1       = vecs[i].r1;
            R2       = vecs[i].r2;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_rd1", i), RD1, vecs[i].e1);
            check($sformatf("vec%0d_rd2", i), RD2, vecs[i].e2);
        end

        // Read-during-write on register 63: old value before the edge, new after.
        @(negedge clk);
        RegWrite = 1'b1;
        WR       = 6'd63;
        WD       = 32'hA5A5_A5A5;
        R1       = 6'd63;
        R2       = 6'd63;
        #1;
        check("rdw_before_rd1", RD1, 32'h1234_5678);
        check("rdw_before_rd2", RD2, 32'h1234_5678);
        @(posedge clk);
        #1;
        check("rdw_after_rd1", RD1, 32'hA5A5_A5A5);
        check("rdw_after_rd2", RD2, 32'hA5A5_A5A5);

        // Read ports follow the address with no clock involved.
        RegWrite = 1'b0;
        R1 = 6'd5;
        R2 = 6'd2;
        #1;
        check("comb_rd1", RD1, 32'hDEAD_BEEF);
        check("comb_rd2", RD2, 32'hFFFF_FFFF);

        // Asynchronous reset between edges clears outputs immediately.
        @(negedge clk);
        R1 = 6'd63;
        R2 = 6'd1;
        #1;
        check("pre_async_rd1", RD1, 32'hA5A5_A5A5);
        check("pre_async_rd2", RD2, 32'h24);
        reset = 1'b1;
        #1;
        check("async_rst_rd1", RD1, 32'h0);
        check("async_rst_rd2", RD2, 32'h0);

        // Write edge while reset held: blocked.
        RegWrite = 1'b1;
        WR       = 6'd3;
        WD       = 32'h0000_0077;
        R1       = 6'd3;
        R2       = 6'd5;
        @(posedge clk);
        #1;
        check("rst_blocks_write", RD1, 32'h0);
        check("rst_cleared_r5", RD2, 32'h0);

        // Release mid-cycle; first write lands on the next edge.
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("release_no_write", RD1, 32'h0);
        @(posedge clk);
        #1;
        check("first_write_after_rst", RD1, 32'h0000_0077);
        check("other_reg_still_zero", RD2, 32'h0);

        @(negedge clk);
        RegWrite = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
